// File: rtl/idli_sqi_ctrl.sv
// SQI memory controller: two 23LC1024 SRAMs in lockstep form one 16-bit word.
// Runs RSTIO/EQIO after reset, then serves single-word reads and writes.
module idli_sqi_ctrl #(
  parameter bit          INIT_EN   = 1'b1,
  parameter int unsigned DUMMY_NIB = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_vld,
  output logic        o_req_rdy,
  input  logic        i_req_wr,
  input  logic [15:0] i_req_addr,
  input  logic [15:0] i_req_data,
  output logic        o_rd_vld,
  output logic [15:0] o_rd_data,
  output logic        o_sqi_sck,
  output logic        o_sqi_cs_n,
  output logic        o_sqi_oe,
  output logic [7:0]  o_sqi_sio,
  input  logic [7:0]  i_sqi_sio
);

  typedef enum logic [3:0] {
    INIT_RST,
    INIT_GAP,
    INIT_EQIO,
    CMD,
    ADDR,
    DUMMY,
    DATA,
    DONE,
    IDLE
  } state_t;

  localparam logic [7:0] EQIO_CMD   = 8'h38;
  localparam logic [3:0] DUMMY_LAST = 4'(DUMMY_NIB - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic        ph;
  logic        boot;
  logic        wr;
  logic [39:0] sh_lo;
  logic [39:0] sh_hi;
  logic [7:0]  eq_sh;
  logic [7:0]  rd_lo;
  logic [7:0]  rd_hi;
  logic [7:0]  cmd;
  logic [39:0] nx_lo;
  logic [39:0] nx_hi;
  logic [7:0]  nx_sio;

  assign cmd    = i_req_wr ? 8'h02 : 8'h03;
  assign nx_lo  = {sh_lo[35:0], 4'h0};
  assign nx_hi  = {sh_hi[35:0], 4'h0};
  assign nx_sio = {nx_hi[39:36], nx_lo[39:36]};

  // Reset parks in DONE; boot decides whether DONE leads to init or IDLE.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= DONE;
      cnt        <= 4'd0;
      ph         <= 1'b0;
      boot       <= INIT_EN;
      wr         <= 1'b0;
      sh_lo      <= '0;
      sh_hi      <= '0;
      eq_sh      <= '0;
      rd_lo      <= '0;
      rd_hi      <= '0;
      o_req_rdy  <= 1'b0;
      o_rd_vld   <= 1'b0;
      o_rd_data  <= '0;
      o_sqi_sck  <= 1'b0;
      o_sqi_cs_n <= 1'b1;
      o_sqi_oe   <= 1'b0;
      o_sqi_sio  <= '0;
    end else begin
      o_rd_vld <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_req_vld && o_req_rdy) begin
            state      <= CMD;
            cnt        <= 4'd1;
            ph         <= 1'b0;
            wr         <= i_req_wr;
            sh_lo      <= {cmd, 8'h00, i_req_addr, i_req_data[7:0]};
            sh_hi      <= {cmd, 8'h00, i_req_addr, i_req_data[15:8]};
            o_req_rdy  <= 1'b0;
            o_sqi_cs_n <= 1'b0;
            o_sqi_oe   <= 1'b1;
            o_sqi_sio  <= {2{cmd[7:4]}};
          end
        end
        DONE: begin
          if (boot) begin
            boot       <= 1'b0;
            state      <= INIT_RST;
            cnt        <= 4'd1;
            ph         <= 1'b0;
            o_sqi_cs_n <= 1'b0;
            o_sqi_oe   <= 1'b1;
            o_sqi_sio  <= 8'hFF;
          end else begin
            state     <= IDLE;
            o_req_rdy <= 1'b1;
          end
        end
        INIT_GAP: begin
          state      <= INIT_EQIO;
          cnt        <= 4'd7;
          ph         <= 1'b0;
          eq_sh      <= EQIO_CMD;
          o_sqi_cs_n <= 1'b0;
          o_sqi_oe   <= 1'b1;
          o_sqi_sio  <= {2{3'b110, EQIO_CMD[7]}};
        end
        INIT_RST, INIT_EQIO, CMD, ADDR, DUMMY, DATA: begin
          ph        <= ~ph;
          o_sqi_sck <= ~ph;
          if (!ph) begin
            // Rising sck edge: memory has held the nibble since the falling one.
            if (state == DATA) begin
              rd_lo <= {rd_lo[3:0], i_sqi_sio[3:0]};
              rd_hi <= {rd_hi[3:0], i_sqi_sio[7:4]};
            end
          end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
            if (state == INIT_EQIO) begin
              eq_sh     <= {eq_sh[6:0], 1'b0};
              o_sqi_sio <= {2{3'b110, eq_sh[6]}};
            end else if (state != INIT_RST) begin
              sh_lo     <= nx_lo;
              sh_hi     <= nx_hi;
              o_sqi_sio <= o_sqi_oe ? nx_sio : 8'h00;
            end
          end else begin
            case (state)
              INIT_RST: begin
                state      <= INIT_GAP;
                o_sqi_cs_n <= 1'b1;
                o_sqi_oe   <= 1'b0;
                o_sqi_sio  <= 8'h00;
              end
              CMD: begin
                state     <= ADDR;
                cnt       <= 4'd5;
                sh_lo     <= nx_lo;
                sh_hi     <= nx_hi;
                o_sqi_sio <= nx_sio;
              end
              ADDR: begin
                sh_lo <= nx_lo;
                sh_hi <= nx_hi;
                if (wr) begin
                  state     <= DATA;
                  cnt       <= 4'd1;
                  o_sqi_sio <= nx_sio;
                end else begin
                  state     <= DUMMY;
                  cnt       <= DUMMY_LAST;
                  o_sqi_oe  <= 1'b0;
                  o_sqi_sio <= 8'h00;
                end
              end
              DUMMY: begin
                state <= DATA;
                cnt   <= 4'd1;
              end
              default: begin
                state      <= DONE;
                o_sqi_cs_n <= 1'b1;
                o_sqi_oe   <= 1'b0;
                o_sqi_sio  <= 8'h00;
                if (state == DATA && !wr) begin
                  o_rd_vld  <= 1'b1;
                  o_rd_data <= {rd_hi, rd_lo};
                end
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_idli_sqi_ctrl.sv
// Directed bench for idli_sqi_ctrl: default instance plus
// an INIT_EN=0 / DUMMY_NIB=4 instance.
`timescale 1ns/1ps
module tb_idli_sqi_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        vld, wr, rdy, rd_vld, sck, cs_n, oe;
  logic [15:0] addr, data, rd_data;
  logic [7:0]  sio, sio_in;

  logic        vld2, wr2, rdy2, rd_vld2, sck2, cs_n2, oe2;
  logic [15:0] addr2, data2, rd_data2;
  logic [7:0]  sio2, sio_in2;

  int n_run  = 0;
  int n_fail = 0;

  idli_sqi_ctrl dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_vld(vld), .o_req_rdy(rdy), .i_req_wr(wr),
    .i_req_addr(addr), .i_req_data(data),
    .o_rd_vld(rd_vld), .o_rd_data(rd_data),
    .o_sqi_sck(sck), .o_sqi_cs_n(cs_n), .o_sqi_oe(oe),
    .o_sqi_sio(sio), .i_sqi_sio(sio_in)
  );

  idli_sqi_ctrl #(.INIT_EN(1'b0), .DUMMY_NIB(4)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_vld(vld2), .o_req_rdy(rdy2), .i_req_wr(wr2),
    .i_req_addr(addr2), .i_req_data(data2),
    .o_rd_vld(rd_vld2), .o_rd_data(rd_data2),
    .o_sqi_sck(sck2), .o_sqi_cs_n(cs_n2), .o_sqi_oe(oe2),
    .o_sqi_sio(sio2), .i_sqi_sio(sio_in2)
  );

  task automatic wait_rdy(input bit sel, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if ((sel ? rdy2 : rdy) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [7:0]  eq;
    logic [11:0] got, exp, msk;
    logic        b;
    eq = 8'h38;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_run++;
    if ({sck, cs_n, oe, sio} !== {1'b0, 1'b1, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_sqi got=%h want=%h", {sck, cs_n, oe, sio}, 11'h200);
    end
    n_run++;
    if ({rdy, rd_vld, rd_data} !== 18'h0) begin
      n_fail++;
      $display("FAIL reset_req got rdy=%b vld=%b data=%h want 0", rdy, rd_vld, rd_data);
    end
    rst_n = 1'b1;
    for (int n = 1; n <= 23; n++) begin
      @(negedge clk);
      got = {rdy, cs_n, oe, sck, sio};
      msk = 12'hFFF;
      if (n <= 4) begin
        exp = {1'b0, 1'b0, 1'b1, (n % 2 == 0), 8'hFF};
      end else if (n == 5 || n == 22) begin
        exp = 12'h400;
        msk = 12'hD00;
      end else if (n <= 21) begin
        b = eq[7 - (n - 6) / 2];
        exp = {1'b0, 1'b0, 1'b1, (n % 2 == 1), 3'b110, b, 3'b110, b};
      end else begin
        exp = 12'hC00;
        msk = 12'hD00;
      end
      n_run++;
      if ((got & msk) !== (exp & msk)) begin
        n_fail++;
        $display("FAIL init_cycle%0d got=%h want=%h mask=%h", n, got, exp, msk);
      end
      if (n == 1) begin
        n_run++;
        if ({rdy2, cs_n2} !== 2'b11) begin
          n_fail++;
          $display("FAIL noinit_rdy_c1 got rdy=%b cs_n=%b want 1 1", rdy2, cs_n2);
        end
      end
    end
  endtask

  task automatic test_write();
    logic [39:0] lo, hi;
    logic [12:0] got, exp, msk;
    bit ok;
    int k;
    lo = 40'h02_00_0012_C3;
    hi = 40'h02_00_0012_A5;
    wait_rdy(1'b0, ok);
    if (!ok) begin
      n_run++; n_fail++;
      $display("FAIL write_wait_rdy timeout");
    end
    vld = 1'b1; wr = 1'b1; addr = 16'h0012; data = 16'hA5C3;
    @(posedge clk);
    #1 vld = 1'b0;
    for (int n = 1; n <= 22; n++) begin
      @(negedge clk);
      got = {rdy, cs_n, oe, sck, rd_vld, sio};
      msk = 13'h1FFF;
      if (n <= 20) begin
        k = (n - 1) / 2;
        exp = {1'b0, 1'b0, 1'b1, (n % 2 == 0), 1'b0,
               hi[39 - 4*k -: 4], lo[39 - 4*k -: 4]};
      end else begin
        exp = {(n == 22), 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        msk = 13'h1B00;
      end
      n_run++;
      if ((got & msk) !== (exp & msk)) begin
        n_fail++;
        $display("FAIL write_cycle%0d got=%h want=%h mask=%h", n, got, exp, msk);
      end
    end
  endtask

  task automatic test_read();
    logic [31:0] cmd;
    logic [12:0] got, exp, msk;
    bit ok;
    int k;
    cmd = 32'h03_00_0012;
    sio_in = 8'h66;
    wait_rdy(1'b0, ok);
    if (!ok) begin
      n_run++; n_fail++;
      $display("FAIL read_wait_rdy timeout");
    end
    vld = 1'b1; wr = 1'b0; addr = 16'h0012; data = 16'h0000;
    @(posedge clk);
    #1 vld = 1'b0;
    for (int n = 1; n <= 26; n++) begin
      @(negedge clk);
      got = {rdy, cs_n, oe, sck, rd_vld, sio};
      msk = 13'h1FFF;
      if (n <= 16) begin
        k = (n - 1) / 2;
        exp = {1'b0, 1'b0, 1'b1, (n % 2 == 0), 1'b0,
               cmd[31 - 4*k -: 4], cmd[31 - 4*k -: 4]};
      end else if (n <= 24) begin
        exp = {1'b0, 1'b0, 1'b0, (n % 2 == 0), 1'b0, 8'h00};
      end else begin
        exp = {(n == 26), 1'b1, 1'b0, 1'b0, (n == 25), 8'h00};
        msk = 13'h1B00;
      end
      n_run++;
      if ((got & msk) !== (exp & msk)) begin
        n_fail++;
        $display("FAIL read_cycle%0d got=%h want=%h mask=%h", n, got, exp, msk);
      end
      if (n >= 25) begin
        n_run++;
        if (rd_data !== 16'hA5C3) begin
          n_fail++;
          $display("FAIL read_data_c%0d got=%h want=a5c3", n, rd_data);
        end
      end
      sio_in = (n == 21) ? 8'hAC : (n == 23) ? 8'h53 : 8'h66;
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int first_rdy, cs_hi, vld_cnt;
    first_rdy = 0; cs_hi = 0; vld_cnt = 0;
    sio_in = 8'h66;
    wait_rdy(1'b0, ok);
    if (!ok) begin
      n_run++; n_fail++;
      $display("FAIL b2b_wait_rdy timeout");
    end
    vld = 1'b1; wr = 1'b1; addr = 16'h0100; data = 16'h1234;
    @(posedge clk);
    #1 wr = 1'b0; addr = 16'h0200;
    for (int n = 1; n <= 48; n++) begin
      @(negedge clk);
      if (rdy === 1'b1 && first_rdy == 0) first_rdy = n;
      if (n <= 30 && cs_n === 1'b1) cs_hi++;
      if (rd_vld === 1'b1) vld_cnt++;
      if (n == 22) begin
        n_run++;
        if (rd_data !== 16'hA5C3) begin
          n_fail++;
          $display("FAIL b2b_hold_data got=%h want=a5c3", rd_data);
        end
      end
      if (n == 23) vld = 1'b0;
      if (n == 25) begin
        n_run++;
        if (sio !== 8'h33) begin
          n_fail++;
          $display("FAIL b2b_read_cmd got=%h want=33", sio);
        end
      end
      if (n == 47) begin
        n_run++;
        if ({rd_vld, rd_data} !== {1'b1, 16'h1234}) begin
          n_fail++;
          $display("FAIL b2b_read_done got vld=%b data=%h want 1 1234", rd_vld, rd_data);
        end
      end
      sio_in = (n == 43) ? 8'h13 : (n == 45) ? 8'h24 : 8'h66;
    end
    n_run++;
    if (first_rdy != 22) begin
      n_fail++;
      $display("FAIL b2b_accept_gap got=%0d want=22", first_rdy);
    end
    n_run++;
    if (cs_hi < 2) begin
      n_fail++;
      $display("FAIL b2b_cs_gap got=%0d want>=2", cs_hi);
    end
    n_run++;
    if (vld_cnt != 1) begin
      n_fail++;
      $display("FAIL b2b_vld_count got=%0d want=1", vld_cnt);
    end
  endtask

  task automatic test_reset_mid_read();
    bit ok;
    int vld_cnt;
    vld_cnt = 0;
    sio_in = 8'h5A;
    wait_rdy(1'b0, ok);
    if (!ok) begin
      n_run++; n_fail++;
      $display("FAIL rst_wait_rdy timeout");
    end
    vld = 1'b1; wr = 1'b0; addr = 16'h0034;
    @(posedge clk);
    #1 vld = 1'b0;
    repeat (8) @(negedge clk);
    n_run++;
    if (cs_n !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_busy_cs got=%b want=0", cs_n);
    end
    rst_n = 1'b0;
    #1;
    n_run++;
    if ({cs_n, oe, sck, rdy} !== 4'b1000) begin
      n_fail++;
      $display("FAIL rst_async got=%b want=1000", {cs_n, oe, sck, rdy});
    end
    repeat (2) @(negedge clk);
    if (rd_vld === 1'b1) vld_cnt++;
    rst_n = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (rd_vld === 1'b1) vld_cnt++;
      if (n == 1) begin
        n_run++;
        if ({cs_n, sio} !== {1'b0, 8'hFF}) begin
          n_fail++;
          $display("FAIL rst_reinit_c1 got cs_n=%b sio=%h want 0 ff", cs_n, sio);
        end
      end
      if (n == 5) begin
        n_run++;
        if (cs_n !== 1'b1) begin
          n_fail++;
          $display("FAIL rst_reinit_c5 got cs_n=%b want 1", cs_n);
        end
      end
      if (n == 22 || n == 23) begin
        n_run++;
        if (rdy !== (n == 23)) begin
          n_fail++;
          $display("FAIL rst_reinit_rdy_c%0d got=%b want=%b", n, rdy, (n == 23));
        end
      end
    end
    n_run++;
    if (vld_cnt != 0) begin
      n_fail++;
      $display("FAIL rst_no_rd_vld got=%0d want=0", vld_cnt);
    end
  endtask

  task automatic test_dummy4();
    bit ok;
    logic [31:0] cmd;
    logic [12:0] got, exp, msk;
    int k;
    cmd = 32'h03_00_0012;
    sio_in2 = 8'h66;
    wait_rdy(1'b1, ok);
    if (!ok) begin
      n_run++; n_fail++;
      $display("FAIL d4_wait_rdy timeout");
    end
    vld2 = 1'b1; wr2 = 1'b0; addr2 = 16'h0012; data2 = 16'h0000;
    @(posedge clk);
    #1 vld2 = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      got = {rdy2, cs_n2, oe2, sck2, rd_vld2, sio2};
      msk = 13'h1FFF;
      if (n <= 16) begin
        k = (n - 1) / 2;
        exp = {1'b0, 1'b0, 1'b1, (n % 2 == 0), 1'b0,
               cmd[31 - 4*k -: 4], cmd[31 - 4*k -: 4]};
      end else if (n <= 28) begin
        exp = {1'b0, 1'b0, 1'b0, (n % 2 == 0), 1'b0, 8'h00};
      end else begin
        exp = {(n == 30), 1'b1, 1'b0, 1'b0, (n == 29), 8'h00};
        msk = 13'h1B00;
      end
      n_run++;
      if ((got & msk) !== (exp & msk)) begin
        n_fail++;
        $display("FAIL d4_cycle%0d got=%h want=%h mask=%h", n, got, exp, msk);
      end
      if (n == 29) begin
        n_run++;
        if (rd_data2 !== 16'h936E) begin
          n_fail++;
          $display("FAIL d4_data got=%h want=936e", rd_data2);
        end
      end
      sio_in2 = (n == 25) ? 8'h96 : (n == 27) ? 8'h3E : 8'h66;
    end
  endtask

  initial begin
    vld = 1'b0; wr = 1'b0; addr = '0; data = '0; sio_in = 8'h66;
    vld2 = 1'b0; wr2 = 1'b0; addr2 = '0; data2 = '0; sio_in2 = 8'h66;
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_reset_mid_read();
    test_dummy4();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/idli_sqi_ctrl.md
Name: idli_sqi_ctrl

Overview:
- Memory-side controller for the two SQI SRAMs (23LC1024-class, one holding low bytes, one holding high bytes).
- Sits directly upstream of fetch/decode, which produces the decoded op. It also serves load/store.
- Accepts single 16-bit word read or write requests and runs both memories in lockstep.
- After reset it forces both memories into quad (SQI) mode.

Parameters:
- INIT_EN, 1, 1 = run the RSTIO/EQIO init sequence after reset; 0 = start directly in IDLE.
- DUMMY_NIB, 2, number of dummy nibble cycles for a read (one dummy byte).

Ports:
- i_clk  in  1  core clock
- i_rst_n  in  1  asynchronous active-low reset
- i_req_vld  in  1  request valid
- o_req_rdy  out  1  controller idle; request accepted when i_req_vld && o_req_rdy
- i_req_wr  in  1  1 = write, 0 = read
- i_req_addr  in  16  word address
- i_req_data  in  16  write data
- o_rd_vld  out  1  one-cycle pulse, read data valid
- o_rd_data  out  16  read data, held until the next read completes
- o_sqi_sck  out  1  SQI clock (i_clk/2, idles low)
- o_sqi_cs_n  out  1  shared chip select
- o_sqi_oe  out  1  1 = controller drives SIO lines
- o_sqi_sio  out  8  [3:0] = SQI_MEM_LO lines, [7:4] = SQI_MEM_HI lines
- i_sqi_sio  in  8  same mapping as o_sqi_sio

Behaviour:
- **Reset values:** o_sqi_sck=0, o_sqi_cs_n=1, o_sqi_oe=0, o_sqi_sio=0, o_req_rdy=0, o_rd_vld=0, o_rd_data=0. All outputs are registered.
- **Nibble timing:** each nibble slot is 2 clk cycles.
  - Phase L: sck=0; the controller updates o_sqi_sio.
  - Phase H: sck=1.
  - Read nibbles are sampled on the clk edge where sck goes 0→1.
- **Nibble order:** each byte goes high nibble first. Both memories receive an identical command and address.
- **States:** INIT_RST, INIT_GAP, INIT_EQIO, CMD, ADDR, DUMMY, DATA, DONE, IDLE.
- **Init sequence (INIT_EN=1).** Cycle 0 is the first posedge with i_rst_n high.
  - INIT_RST, cycles 1–4: cs_n=0, oe=1, two quad nibbles 0xF on all lines (RSTIO 0xFF). This is harmless if the memories are still in SPI mode.
  - INIT_GAP, cycle 5: cs_n=1.
  - INIT_EQIO, cycles 6–21: SPI-mode command 0x38, MSB first, one bit per slot on SIO0 of each memory. SIO[3:2]=1 (HOLD/WP inactive), SIO1=0.
  - DONE, cycle 22: cs_n=1.
  - IDLE: o_req_rdy=1 from cycle 23.
  - With INIT_EN=0, IDLE and o_req_rdy=1 from cycle 1.
- **Request acceptance:** in IDLE, a request is accepted on i_req_vld && o_req_rdy. Address, data and wr are captured, and o_req_rdy drops the next cycle. i_req_vld while not ready is ignored and never queued.
- **Transaction, with k = slot index starting at cycle 1 after acceptance:**
  - CMD: 2 slots. 0x03 for read, 0x02 for write.
  - ADDR: 6 slots carrying the 24-bit address {8'h00, addr}.
  - DUMMY (read only): DUMMY_NIB slots with oe=0.
  - DATA: 2 slots.
    - Write: lo lines get data[7:4] then data[3:0]; hi lines get data[15:12] then data[11:8]; oe=1.
    - Read: oe=0; the same mapping is assembled from the samples.
  - DONE: 1 cycle, cs_n=1, sck=0. For a read, o_rd_vld=1 and o_rd_data is updated in this cycle.
  - IDLE: next cycle.
- **Latency:** read has acceptance→o_rd_vld = 25 cycles, next accept possible 26 cycles after acceptance. Write has 20 cycles cs_n low, next accept possible 22 cycles after acceptance. cs_n is high for at least 2 cycles between transactions.
- **oe turnaround:** oe drops at the start of the first DUMMY slot. The controller never drives SIO while oe=0, and drives o_sqi_sio=0 then.
- **Reset mid-operation:** asynchronous reset aborts immediately. cs_n goes high, no o_rd_vld is issued, and init re-runs if INIT_EN=1.
- **No backpressure:** o_rd_vld has no handshake; the consumer must take the data on the pulse.

Test Plan:
- **Reset/init:** release reset with INIT_EN=1 → cs_n low cycles 1–4 with sio=0xFF; cs_n high cycle 5; cycles 6–21 SIO0 bits 0,0,1,1,1,0,0,0 with SIO[3:2]=11; o_req_rdy=1 at cycle 23.
- **Write:** write 0xA5C3 to addr 0x0012 → both memories see nibbles 0,2 | 0,0,0,0,1,2; lo data C,3; hi data A,5; oe=1 throughout; cs_n low 20 cycles; o_rd_vld stays 0.
- **Read:** read addr 0x0012 with the memory model returning lo 0xC3, hi 0xA5 → command nibbles 0,3; oe=0 from the DUMMY slots; o_rd_vld pulse exactly 25 cycles after acceptance with o_rd_data=0xA5C3.
- **Back-to-back:** i_req_vld held high for write then read → second request accepted 22 cycles after the first; cs_n high ≥2 cycles between them; requests presented while busy are not accepted.
- **Reset mid-read:** assert i_rst_n=0 during the ADDR slot → same cycle cs_n=1, oe=0, sck=0, o_req_rdy=0; no o_rd_vld; full init sequence after release.
- **INIT_EN=0, DUMMY_NIB=4:** o_req_rdy=1 at cycle 1; read latency becomes 29 cycles.
